mc_control_unit: RTL

- Multicycle MIPS control FSM. Successor to the single-cycle `control_unit`.
- Sits between the instruction register (IR) opcode field and the multicycle datapath (PC, memory, IR, register file, ALU muxes).
- Generates per-state Moore control strobes and waits on a memory-ready handshake.
- Opcodes are parametrised; it counts retired instructions and flags illegal opcodes.

---
 rtl/mc_control_unit.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multicycle MIPS control FSM with retired-instruction counter (optional JUMP_EN adds the jump state)
module mc_control_unit #(
    parameter int          CNT_W    = 16,
    parameter logic [5:0]  OP_RTYPE = 6'b000000,
    parameter logic [5:0]  OP_LW    = 6'b100011,
    parameter logic [5:0]  OP_SW    = 6'b101011,
    parameter logic [5:0]  OP_BEQ   = 6'b000100,
    parameter logic [5:0]  OP_ADDI  = 6'b001000,
    parameter logic [5:0]  OP_J     = 6'b000010
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_ILLEGAL = 4'd12
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [5:0] op_q;
    logic       retire;

    assign state = state_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Opcode is captured in DECODE so MEMADR can pick load vs store later
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q <= 6'd0;
        end else if (state_q == S_DECODE) begin
            op_q <= opcode;
        end
    end

    // An instruction retires when a final state hands back to FETCH; ILLEGAL is excluded
    always_comb begin
        retire = 1'b0;
        if (state_d == S_FETCH) begin
            case (state_q)
                S_MEMWB, S_MEMWR, S_RWB, S_BRANCH, S_ADDIWB, S_JUMP: retire = 1'b1;
                default: retire = 1'b0;
            endcase
        end
    end

    // Retired-instruction counter, wraps naturally; reset wins over increment
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_count <= '0;
        end else if (retire) begin
            instr_count <= instr_count + CNT_W'(1);
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW) begin
                    state_d = S_MEMADR;
                end else if (opcode == OP_RTYPE) begin
                    state_d = S_EXEC;
                end else if (opcode == OP_BEQ) begin
                    state_d = S_BRANCH;
                end else if (opcode == OP_ADDI) begin
                    state_d = S_ADDIEX;
`ifdef JUMP_EN
                end else if (opcode == OP_J) begin
                    state_d = S_JUMP;
`else
                end else if (opcode == OP_J) begin
                    state_d = S_ILLEGAL;
`endif
                end else begin
                    state_d = S_ILLEGAL;
                end
            end
            S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: state_d = S_FETCH;
            S_MEMWR: begin
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC:    state_d = S_RWB;
            S_RWB:     state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  state_d = S_FETCH;
`ifdef JUMP_EN
            S_JUMP:    state_d = S_FETCH;
`endif
            S_ILLEGAL: state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    // Moore control strobes decoded from the current state; reset masks all side-effecting strobes
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_RWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: reg_write = 1'b1;
`ifdef JUMP_EN
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
`endif
            S_ILLEGAL: illegal_op = 1'b1;
            default: begin
            end
        endcase
        if (rst) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            reg_write     = 1'b0;
            illegal_op    = 1'b0;
        end
    end

endmodule
